// File: rtl/dma_burst_planner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dma_burst_planner_if
//  Purpose  : Descriptor and burst-request handshake bundle for the DMA burst
//             planner.
//  Ports    : desc_*  - descriptor channel (DMA FSM -> planner)
//             req_*   - burst request channel (planner -> AXI interface)
//  Modports : master  - planner side (accepts descriptors, issues requests)
//             slave   - environment side (issues descriptors, accepts requests)
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_burst_planner_if #(
    parameter int ADDR_W  = 32,
    parameter int BYTES_W = 32,
    parameter int ROWS_W  = 16,
    parameter int HEAD_W  = 6
);
    // Descriptor channel
    logic               desc_valid_i;
    logic               desc_ready_o;
    logic [ADDR_W-1:0]  desc_addr_i;
    logic [BYTES_W-1:0] desc_bytes_i;
    logic [ROWS_W-1:0]  desc_rows_i;
    logic [ADDR_W-1:0]  desc_stride_i;

    // Burst request channel
    logic               req_valid_o;
    logic               req_ready_i;
    logic [ADDR_W-1:0]  req_addr_o;
    logic [7:0]         req_len_o;
    logic [2:0]         req_size_o;
    logic [HEAD_W-1:0]  req_head_o;
    logic [HEAD_W-1:0]  req_tail_o;
    logic               req_last_o;

    modport master (
        input  desc_valid_i, desc_addr_i, desc_bytes_i, desc_rows_i, desc_stride_i,
        input  req_ready_i,
        output desc_ready_o,
        output req_valid_o, req_addr_o, req_len_o, req_size_o,
        output req_head_o, req_tail_o, req_last_o
    );

    modport slave (
        output desc_valid_i, desc_addr_i, desc_bytes_i, desc_rows_i, desc_stride_i,
        output req_ready_i,
        input  desc_ready_o,
        input  req_valid_o, req_addr_o, req_len_o, req_size_o,
        input  req_head_o, req_tail_o, req_last_o
    );
endinterface
`default_nettype wire

// File: rtl/dma_burst_planner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dma_burst_planner
//  Purpose  : Splits a (optionally 2D) DMA descriptor into AXI INCR burst
//             requests. Bursts are beat-aligned, never cross a BOUND-byte
//             boundary and never exceed MAX_BEATS beats. Head/tail byte
//             offsets are reported for the downstream shift aligner.
//  Ports    : clk, rst    - clock, synchronous active-high reset
//             bus         - descriptor + request channels (master modport)
//             done_o      - one-cycle pulse when the last burst is accepted
//             err_o       - one-cycle pulse on a rejected descriptor
//             err_code_o  - 1: zero bytes/rows, 2: stride < bytes (held)
//             busy_o      - descriptor in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dma_burst_planner #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 32,
    parameter int BYTES_W   = 32,
    parameter int ROWS_W    = 16,
    parameter int MAX_BEATS = 256,
    parameter int BOUND     = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dma_burst_planner_if.master bus,
    output      logic          done_o,
    output      logic          err_o,
    output      logic [1:0]    err_code_o,
    output      logic          busy_o
);

    localparam int c_BPB       = DATA_W / 8;
    localparam int c_HEAD_W    = $clog2(c_BPB);
    localparam int c_BOUND_LOG = $clog2(BOUND);
    localparam int c_MAX_BYTES = MAX_BEATS * c_BPB;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Working width wide enough for every byte quantity plus a carry bit.
    localparam int CW = max2(max2(ADDR_W, BYTES_W),
                             max2(c_BOUND_LOG, $clog2(c_MAX_BYTES)) + 1) + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cursor_q, cursor_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d;
    logic [ADDR_W-1:0]     stride_q, stride_d;
    logic [BYTES_W-1:0]    bytes_q, bytes_d;
    logic [BYTES_W-1:0]    row_left_q, row_left_d;
    logic [ROWS_W-1:0]     rows_left_q, rows_left_d;
    logic                  last_loaded_q, last_loaded_d;

    logic                  req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic [7:0]            req_len_q, req_len_d;
    logic [2:0]            req_size_q, req_size_d;
    logic [c_HEAD_W-1:0]   req_head_q, req_head_d;
    logic [c_HEAD_W-1:0]   req_tail_q, req_tail_d;
    logic                  req_last_q, req_last_d;

    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    // Burst source: in IDLE the first burst is planned straight from the
    // descriptor inputs so the first request appears one cycle after accept.
    logic                  w_idle;
    logic [ADDR_W-1:0]     w_cur, w_base, w_stride;
    logic [BYTES_W-1:0]    w_left, w_bytes;
    logic [ROWS_W-1:0]     w_rows;

    logic [CW-1:0]         w_head, w_to_bound, w_room, w_left_c, w_chunk;
    logic [CW-1:0]         w_end, w_beats;
    logic [c_HEAD_W-1:0]   w_tail;
    logic                  w_row_done, w_final;
    logic                  w_accept, w_zero_err, w_stride_err, w_load, w_last_hs;

    always_comb begin
        w_idle   = (state_q == S_IDLE);
        w_cur    = w_idle ? bus.desc_addr_i   : cursor_q;
        w_base   = w_idle ? bus.desc_addr_i   : row_base_q;
        w_stride = w_idle ? bus.desc_stride_i : stride_q;
        w_left   = w_idle ? bus.desc_bytes_i  : row_left_q;
        w_bytes  = w_idle ? bus.desc_bytes_i  : bytes_q;
        w_rows   = w_idle ? bus.desc_rows_i   : rows_left_q;

        w_head     = CW'(w_cur[c_HEAD_W-1:0]);
        w_to_bound = CW'(BOUND) - CW'(w_cur[c_BOUND_LOG-1:0]);
        w_room     = CW'(c_MAX_BYTES) - w_head;
        w_left_c   = CW'(w_left);

        w_chunk = w_left_c;
        if (w_to_bound < w_chunk) w_chunk = w_to_bound;
        if (w_room < w_chunk)     w_chunk = w_room;

        w_end   = w_head + w_chunk;
        w_beats = (w_end + CW'(c_BPB - 1)) >> c_HEAD_W;
        // Two's-complement negate of the low bits == (BPB - end%BPB) % BPB.
        w_tail  = ~w_end[c_HEAD_W-1:0] + c_HEAD_W'(1);

        w_row_done = (w_chunk == w_left_c);
        w_final    = w_row_done && (w_rows == ROWS_W'(1));

        w_accept     = w_idle && bus.desc_valid_i;
        w_zero_err   = (bus.desc_bytes_i == '0) || (bus.desc_rows_i == '0);
        w_stride_err = (bus.desc_rows_i > ROWS_W'(1)) &&
                       (CW'(bus.desc_stride_i) < CW'(bus.desc_bytes_i));

        w_load    = (w_accept && !w_zero_err && !w_stride_err) ||
                    (!w_idle && !last_loaded_q && (!req_valid_q || bus.req_ready_i));
        w_last_hs = !w_idle && req_valid_q && bus.req_ready_i && req_last_q;
    end

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        row_base_d    = row_base_q;
        stride_d      = stride_q;
        bytes_d       = bytes_q;
        row_left_d    = row_left_q;
        rows_left_d   = rows_left_q;
        last_loaded_d = last_loaded_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_len_d     = req_len_q;
        req_size_d    = req_size_q;
        req_head_d    = req_head_q;
        req_tail_d    = req_tail_q;
        req_last_d    = req_last_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;

        if (w_accept) begin
            if (w_zero_err) begin
                err_d      = 1'b1;
                err_code_d = 2'd1;
            end else if (w_stride_err) begin
                err_d      = 1'b1;
                err_code_d = 2'd2;
            end else begin
                state_d  = S_RUN;
                stride_d = bus.desc_stride_i;
                bytes_d  = bus.desc_bytes_i;
            end
        end

        if (w_last_hs) begin
            req_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
        end

        if (w_load) begin
            req_valid_d   = 1'b1;
            req_addr_d    = {w_cur[ADDR_W-1:c_HEAD_W], {c_HEAD_W{1'b0}}};
            req_len_d     = 8'(w_beats - CW'(1));
            req_size_d    = 3'(c_HEAD_W);
            req_head_d    = w_cur[c_HEAD_W-1:0];
            req_tail_d    = w_tail;
            req_last_d    = w_final;
            last_loaded_d = w_final;
            if (w_row_done && !w_final) begin
                // Row exhausted: jump to the next row start.
                row_base_d  = w_base + w_stride;
                cursor_d    = w_base + w_stride;
                row_left_d  = w_bytes;
                rows_left_d = w_rows - ROWS_W'(1);
            end else begin
                row_base_d  = w_base;
                cursor_d    = w_cur + ADDR_W'(w_chunk);
                row_left_d  = w_left - BYTES_W'(w_chunk);
                rows_left_d = w_rows;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cursor_q      <= '0;
            row_base_q    <= '0;
            stride_q      <= '0;
            bytes_q       <= '0;
            row_left_q    <= '0;
            rows_left_q   <= '0;
            last_loaded_q <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_len_q     <= '0;
            req_size_q    <= '0;
            req_head_q    <= '0;
            req_tail_q    <= '0;
            req_last_q    <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            row_base_q    <= row_base_d;
            stride_q      <= stride_d;
            bytes_q       <= bytes_d;
            row_left_q    <= row_left_d;
            rows_left_q   <= rows_left_d;
            last_loaded_q <= last_loaded_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_len_q     <= req_len_d;
            req_size_q    <= req_size_d;
            req_head_q    <= req_head_d;
            req_tail_q    <= req_tail_d;
            req_last_q    <= req_last_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.desc_ready_o = (state_q == S_IDLE);
    assign bus.req_valid_o  = req_valid_q;
    assign bus.req_addr_o   = req_addr_q;
    assign bus.req_len_o    = req_len_q;
    assign bus.req_size_o   = req_size_q;
    assign bus.req_head_o   = req_head_q;
    assign bus.req_tail_o   = req_tail_q;
    assign bus.req_last_o   = req_last_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign err_code_o       = err_code_q;
    assign busy_o           = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dma_burst_planner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dma_burst_planner
//  Purpose  : Self-checking bench for dma_burst_planner (DATA_W=512,
//             MAX_BEATS=16, BOUND=4096). Expected bursts come from a
//             descriptor-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_burst_planner;

    localparam int DATA_W = 512;
    localparam int BPB    = DATA_W / 8;
    localparam int MAXB   = 16;
    localparam int BOUND  = 4096;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  head;
        logic [5:0]  tail;
        logic        last;
    } burst_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_o, err_o, busy_o;
    logic [1:0] err_code_o;

    int n_tests = 0;
    int n_fail  = 0;

    burst_t exp_q[$];

    dma_burst_planner_if #(.ADDR_W(32), .BYTES_W(32), .ROWS_W(16), .HEAD_W(6)) bus ();

    dma_burst_planner #(
        .DATA_W(DATA_W), .ADDR_W(32), .BYTES_W(32), .ROWS_W(16),
        .MAX_BEATS(MAXB), .BOUND(BOUND)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk each row, carving chunks by the three limits.
    function automatic void build(input logic [31:0] a, input int nb, input int nr,
                                  input logic [31:0] st);
        logic [31:0] cur;
        longint      left, head, to_b, room, chunk, fin_b;
        burst_t      b;
        exp_q.delete();
        for (int r = 0; r < nr; r++) begin
            cur  = a + st * 32'(r);
            left = longint'(nb);
            while (left > 0) begin
                head  = longint'(cur % 32'(BPB));
                to_b  = longint'(BOUND) - longint'(cur % 32'(BOUND));
                room  = longint'(MAXB * BPB) - head;
                chunk = left;
                if (to_b < chunk) chunk = to_b;
                if (room < chunk) chunk = room;
                fin_b  = head + chunk;
                b.addr = cur & ~32'(BPB - 1);
                b.len  = 8'((fin_b + BPB - 1) / BPB - 1);
                b.head = 6'(head);
                b.tail = 6'((BPB - fin_b % BPB) % BPB);
                b.last = (r == nr - 1) && (left == chunk);
                exp_q.push_back(b);
                cur  = cur + 32'(chunk);
                left = left - chunk;
            end
        end
    endfunction

    // mode 0: always ready (no gaps allowed); 1: random ready; 2: 5-cycle stall
    task automatic run_desc(input logic [31:0] a, input int nb, input int nr,
                            input logic [31:0] st, input int mode);
        burst_t obs, held, cur_exp;
        bit     have_held, hs, fin, rdy;
        int     cyc;
        build(a, nb, nr, st);
        bus.desc_addr_i   = a;
        bus.desc_bytes_i  = 32'(nb);
        bus.desc_rows_i   = 16'(nr);
        bus.desc_stride_i = st;
        bus.desc_valid_i  = 1'b1;
        bus.req_ready_i   = 1'b0;
        @(posedge clk); #1;
        bus.desc_valid_i = 1'b0;
        check("lat1_valid", bus.req_valid_o, 1);
        check("run_busy", busy_o, 1);
        check("run_dready", bus.desc_ready_o, 0);
        fin = 0; cyc = 0; have_held = 0;
        while (!fin && cyc < 4000) begin
            obs = {bus.req_addr_o, bus.req_len_o, bus.req_head_o, bus.req_tail_o, bus.req_last_o};
            if (bus.req_valid_o) begin
                if (exp_q.size() == 0) check("extra_burst", bus.req_valid_o, 0);
                else begin
                    cur_exp = exp_q[0];
                    check("burst", obs, cur_exp);
                end
                if (have_held) check("hold_stable", obs, held);
                check("req_size", bus.req_size_o, 6);
            end else if (mode == 0) begin
                check("gap_valid", bus.req_valid_o, 1);
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom_range(0, 1));
            else                rdy = !(cyc >= 1 && cyc < 6);
            bus.req_ready_i = rdy;
            // Descriptor noise while running must be ignored.
            bus.desc_valid_i  = 1'($urandom_range(0, 1));
            bus.desc_addr_i   = $urandom();
            bus.desc_bytes_i  = $urandom();
            bus.desc_rows_i   = 16'($urandom());
            bus.desc_stride_i = $urandom();
            hs        = bus.req_valid_o && rdy;
            have_held = bus.req_valid_o && !rdy;
            held      = obs;
            @(posedge clk); #1;
            if (hs && exp_q.size() > 0) begin
                cur_exp = exp_q.pop_front();
                if (cur_exp.last) begin
                    fin = 1;
                    bus.desc_valid_i = 1'b0;
                    check("done_pulse", done_o, 1);
                    check("done_valid_drop", bus.req_valid_o, 0);
                    check("done_dready", bus.desc_ready_o, 1);
                    check("done_busy", busy_o, 0);
                end else begin
                    check("no_done", done_o, 0);
                end
            end else begin
                check("no_done", done_o, 0);
            end
            cyc++;
        end
        bus.desc_valid_i = 1'b0;
        bus.req_ready_i  = 1'b0;
        if (!fin) check("timeout_done", 64'(fin), 64'(1));
        @(posedge clk); #1;
        check("done_one_cycle", done_o, 0);
    endtask

    task automatic err_desc(input int nb, input int nr, input logic [31:0] st, input int code);
        bus.desc_addr_i   = 32'h0000_4000;
        bus.desc_bytes_i  = 32'(nb);
        bus.desc_rows_i   = 16'(nr);
        bus.desc_stride_i = st;
        bus.desc_valid_i  = 1'b1;
        @(posedge clk); #1;
        bus.desc_valid_i = 1'b0;
        check("err_pulse", err_o, 1);
        check("err_code", err_code_o, 64'(code));
        check("err_no_req", bus.req_valid_o, 0);
        check("err_idle", bus.desc_ready_o, 1);
        @(posedge clk); #1;
        check("err_drop", err_o, 0);
        check("err_code_held", err_code_o, 64'(code));
        check("err_no_req2", bus.req_valid_o, 0);
    endtask

    initial begin
        logic [31:0] ra, rs;
        int          rb, rr, rm;
        bus.desc_valid_i  = 1'b0;
        bus.desc_addr_i   = '0;
        bus.desc_bytes_i  = '0;
        bus.desc_rows_i   = '0;
        bus.desc_stride_i = '0;
        bus.req_ready_i   = 1'b0;

        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_outs",
              {bus.desc_ready_o, bus.req_valid_o, bus.req_addr_o, bus.req_len_o, bus.req_size_o,
               bus.req_head_o, bus.req_tail_o, bus.req_last_o, done_o, err_o, err_code_o, busy_o},
              {1'b1, 62'd0});
        rst = 1'b0;
        @(posedge clk); #1;

        run_desc(32'h0000_1000, 128, 1, 32'h0, 0);
        run_desc(32'h0000_1010, 100, 1, 32'h0, 1);
        run_desc(32'h0000_0FC0, 128, 1, 32'h0, 0);
        run_desc(32'h0000_0000, 2048, 1, 32'h0, 0);
        run_desc(32'h0000_0000, 2048, 1, 32'h0, 2);
        run_desc(32'h0000_2000, 64, 3, 32'h100, 1);
        run_desc(32'h0000_0FF1, 5000, 2, 32'h2000, 2);

        err_desc(0, 1, 32'h0, 1);
        err_desc(64, 0, 32'h0, 1);
        err_desc(256, 2, 32'd128, 2);

        // Reset in the middle of a long stalled descriptor.
        bus.desc_addr_i   = 32'h0000_0000;
        bus.desc_bytes_i  = 32'd16384;
        bus.desc_rows_i   = 16'd1;
        bus.desc_stride_i = 32'h0;
        bus.desc_valid_i  = 1'b1;
        bus.req_ready_i   = 1'b0;
        @(posedge clk); #1;
        bus.desc_valid_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("pre_rst_valid", bus.req_valid_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_outs",
              {bus.desc_ready_o, bus.req_valid_o, bus.req_addr_o, bus.req_len_o, bus.req_size_o,
               bus.req_head_o, bus.req_tail_o, bus.req_last_o, done_o, err_o, err_code_o, busy_o},
              {1'b1, 62'd0});
        rst = 1'b0;
        bus.req_ready_i = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_done", done_o, 0);
        check("post_rst_no_req", bus.req_valid_o, 0);
        bus.req_ready_i = 1'b0;

        for (int i = 0; i < 25; i++) begin
            ra = $urandom();
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_F000 | ($urandom() & 32'h0000_0FFF);
            rb = int'($urandom_range(1, 5000));
            rr = int'($urandom_range(1, 3));
            rs = 32'(rb) + 32'($urandom_range(0, 512));
            rm = int'($urandom_range(0, 1));
            run_desc(ra, rb, rr, rs, rm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
